axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
- Shares one AXI-Stream master output between NUM_STREAMS slave inputs.
- Arbitration is round-robin at packet granularity. Once a grant is issued, it is held until the granted input's tlast beat completes a handshake.
- Sits upstream of shared sinks (packet FIFOs, framers, broadcaster inputs) to merge multiple packet sources. It is the fan-in counterpart to the broadcaster fan-out.
- Output tid reports the source index of the current packet.

Parameters:
- AXIS_BYTES, 1, tdata width in bytes per stream.
- AXIS_USER_BITS, 1, tuser width per stream.
- NUM_STREAMS, 2, number of slave inputs (≥2).
- ID_BITS, $clog2(NUM_STREAMS), width of axis_o_tid.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- sreset  input  1  synchronous reset, active-high.
- axis_i_tready  output  NUM_STREAMS  per-input ready; bit i belongs to stream i.
- axis_i_tvalid  input  NUM_STREAMS  per-input valid.
- axis_i_tlast  input  NUM_STREAMS  per-input last.
- axis_i_tdata  input  NUM_STREAMS*AXIS_BYTES*8  stream i occupies slice [i*AXIS_BYTES*8 +: AXIS_BYTES*8].
- axis_i_tuser  input  NUM_STREAMS*AXIS_USER_BITS  stream i occupies slice [i*AXIS_USER_BITS +: AXIS_USER_BITS].
- axis_o_tready  input  1  downstream ready.
- axis_o_tvalid  output  1  output valid.
- axis_o_tlast  output  1  output last.
- axis_o_tdata  output  AXIS_BYTES*8  output data.
- axis_o_tuser  output  AXIS_USER_BITS  output user.
- axis_o_tid  output  ID_BITS  index of the granted input.

Behaviour:
- Reset (sreset=1 at a clock edge), regardless of current state:
  - state=IDLE, grant=0, last_grant=NUM_STREAMS-1, so input 0 wins first.
  - Next cycle: axis_o_tvalid=0, axis_i_tready=all 0, axis_o_tid=0.
  - A packet cut off by reset is abandoned. No tlast is fabricated.
- FSM states: IDLE and BUSY.
- IDLE:
  - axis_o_tvalid=0 and all axis_i_tready=0.
  - If any axis_i_tvalid bit is set, register grant = first index with tvalid set, scanning last_grant+1, last_grant+2, ... modulo NUM_STREAMS. Then go to BUSY.
  - If no bit is set, stay in IDLE.
  - Arbitration therefore costs exactly one bubble cycle before each packet.
- BUSY:
  - Purely combinational path: axis_o_tvalid/tlast/tdata/tuser = the granted input's signals.
  - axis_i_tready[grant] = axis_o_tready; all other tready bits = 0.
  - axis_o_tid = grant. It is stable for the whole packet.
  - On a beat with axis_o_tvalid & axis_o_tready & axis_o_tlast: last_grant <= grant, state <= IDLE.
  - Beats without tlast keep BUSY and keep the grant.
- Granted input drops tvalid mid-packet: hold BUSY and the grant; output tvalid follows it low. Other requesters never preempt.
- Single requester: it is re-granted after one idle cycle, so one packet is delivered per (length+1) cycles minimum.
- Requests arriving in the same cycle as a tlast handshake are evaluated in the following IDLE cycle, using the updated last_grant.
- Index wrap: a search starting from last_grant=NUM_STREAMS-1 begins at index 0.
- Non-power-of-two NUM_STREAMS: grant never takes a value ≥ NUM_STREAMS.
- Non-granted inputs see tready=0 at all times, so their data is held per AXI-S rules.
- No throughput register stage; combinational depth is one NUM_STREAMS:1 mux.

Test Plan:
- Reset, then inputs 0 and 1 both present 3-beat packets (tdata 0x10..0x12 and 0x20..0x22), tready=1 → output 0x10,0x11,0x12 (tid=0), one idle cycle, then 0x20,0x21,0x22 (tid=1). axis_i_tready[1]=0 throughout packet 0.
- NUM_STREAMS=3, all inputs continuously send 1-beat packets → tid sequence 0,1,2,0,1,2 with a tvalid=0 cycle between each.
- Granted input 1 drops tvalid for 4 cycles mid-packet while input 0 is valid → output tvalid low for 4 cycles, tid stays 1, input 0 not served until input 1's tlast completes.
- axis_o_tready toggles 1,0,1,0 during a 4-beat packet from input 2 → each beat appears once, axis_i_tready[2] mirrors axis_o_tready, tdata stable while stalled.
- Assert sreset mid-packet (beat 2 of 5 from input 1), then release with inputs 0 and 1 valid → tvalid=0 the cycle after reset, next grant is input 0 (tid=0).
- Only input 1 sends back-to-back 2-beat packets, tready=1 → tid always 1, throughput 2 beats per 3 cycles.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter: merges NUM_STREAMS slave inputs
// onto one master output, holding each grant until the granted input's tlast handshakes.
module axis_packet_arbiter #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_STREAMS    = 2,
  parameter int ID_BITS        = $clog2(NUM_STREAMS)
) (
  input  logic                                    clk,
  input  logic                                    sreset,
  output logic [NUM_STREAMS-1:0]                  axis_i_tready,
  input  logic [NUM_STREAMS-1:0]                  axis_i_tvalid,
  input  logic [NUM_STREAMS-1:0]                  axis_i_tlast,
  input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0]     axis_i_tdata,
  input  logic [NUM_STREAMS*AXIS_USER_BITS-1:0]   axis_i_tuser,
  input  logic                                    axis_o_tready,
  output logic                                    axis_o_tvalid,
  output logic                                    axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]                 axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]               axis_o_tuser,
  output logic [ID_BITS-1:0]                      axis_o_tid
);

  localparam int DATA_W = AXIS_BYTES * 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [ID_BITS-1:0]  grant_q, grant_d;
  logic [ID_BITS-1:0]  last_grant_q, last_grant_d;
  logic [ID_BITS-1:0]  rr_pick;
  logic [ID_BITS-1:0]  rr_idx;
  logic                rr_found;
  logic                busy;

  logic [DATA_W-1:0]         data_arr [NUM_STREAMS];
  logic [AXIS_USER_BITS-1:0] user_arr [NUM_STREAMS];

  assign busy = (state_q == ST_BUSY);

  // Only the granted input ever sees ready, so everyone else holds their beat.
  generate
    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_in
      assign data_arr[gi]      = axis_i_tdata[gi*DATA_W +: DATA_W];
      assign user_arr[gi]      = axis_i_tuser[gi*AXIS_USER_BITS +: AXIS_USER_BITS];
      assign axis_i_tready[gi] = busy && (grant_q == ID_BITS'(gi)) && axis_o_tready;
    end
  endgenerate

  always_comb begin
    axis_o_tvalid = busy && axis_i_tvalid[grant_q];
    axis_o_tlast  = axis_i_tlast[grant_q];
    axis_o_tdata  = data_arr[grant_q];
    axis_o_tuser  = user_arr[grant_q];
    axis_o_tid    = grant_q;
  end

  // Scan starts just after the previous winner and wraps modulo NUM_STREAMS.
  always_comb begin
    rr_pick  = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      rr_idx = ID_BITS'((int'(last_grant_q) + k) % NUM_STREAMS);
      if (!rr_found && axis_i_tvalid[rr_idx]) begin
        rr_pick  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE) begin
      if (rr_found) begin
        grant_d = rr_pick;
        state_d = ST_BUSY;
      end
    end else begin
      if (axis_o_tvalid && axis_o_tready && axis_o_tlast) begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_BITS'(NUM_STREAMS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomised scoreboard bench for axis_packet_arbiter (3 streams, non-power-of-two),
// followed by a directed mid-packet reset.
module tb_axis_packet_arbiter;

  localparam int NS    = 3;
  localparam int UB    = 2;
  localparam int IDB   = 2;
  localparam int DEPTH = 1024;

  logic                clk = 1'b0;
  logic                sreset;
  logic [NS-1:0]       axis_i_tready;
  logic [NS-1:0]       axis_i_tvalid;
  logic [NS-1:0]       axis_i_tlast;
  logic [NS*8-1:0]     axis_i_tdata;
  logic [NS*UB-1:0]    axis_i_tuser;
  logic                axis_o_tready;
  logic                axis_o_tvalid;
  logic                axis_o_tlast;
  logic [7:0]          axis_o_tdata;
  logic [UB-1:0]       axis_o_tuser;
  logic [IDB-1:0]      axis_o_tid;

  axis_packet_arbiter #(
    .AXIS_BYTES     (1),
    .AXIS_USER_BITS (UB),
    .NUM_STREAMS    (NS),
    .ID_BITS        (IDB)
  ) dut (
    .clk           (clk),
    .sreset        (sreset),
    .axis_i_tready (axis_i_tready),
    .axis_i_tvalid (axis_i_tvalid),
    .axis_i_tlast  (axis_i_tlast),
    .axis_i_tdata  (axis_i_tdata),
    .axis_i_tuser  (axis_i_tuser),
    .axis_o_tready (axis_o_tready),
    .axis_o_tvalid (axis_o_tvalid),
    .axis_o_tlast  (axis_o_tlast),
    .axis_o_tdata  (axis_o_tdata),
    .axis_o_tuser  (axis_o_tuser),
    .axis_o_tid    (axis_o_tid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    data;
    logic [UB-1:0] user;
    logic          last;
  } beat_t;

  // Per-source scoreboard: beats are pushed when generated, popped by the monitor.
  beat_t exp_mem [NS][DEPTH];
  int    wr_ptr [NS];
  int    rd_ptr [NS];
  int    drv_ptr[NS];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state: packet in flight, its owner and the previous owner.
  bit m_busy;
  int m_grant;
  int m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: compares the DUT against the round-robin packet model every cycle.
  initial begin
    logic [NS-1:0] exp_rdy;
    beat_t         e;
    int            cand;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (!m_busy) begin
          check("idle_tvalid", 32'(axis_o_tvalid), 32'd0);
          check("idle_tready", 32'(axis_i_tready), 32'd0);
          if (|axis_i_tvalid) begin
            for (int k = 1; k <= NS; k++) begin
              cand = (m_last + k) % NS;
              if (axis_i_tvalid[cand]) begin
                m_grant = cand;
                break;
              end
            end
            m_busy = 1'b1;
          end
        end else begin
          check("tid", 32'(axis_o_tid), 32'(m_grant));
          check("out_tvalid", 32'(axis_o_tvalid), 32'(axis_i_tvalid[m_grant]));
          exp_rdy = '0;
          exp_rdy[m_grant] = axis_o_tready;
          check("in_tready", 32'(axis_i_tready), 32'(exp_rdy));
          if (axis_o_tvalid && axis_o_tready) begin
            if (rd_ptr[m_grant] == wr_ptr[m_grant]) begin
              check("beat_expected", 32'd0, 32'd1);
            end else begin
              e = exp_mem[m_grant][rd_ptr[m_grant] % DEPTH];
              $display("beat src=%0d data=%02h user=%0h last=%0b",
                       axis_o_tid, axis_o_tdata, axis_o_tuser, axis_o_tlast);
              check("out_tdata", 32'(axis_o_tdata), 32'(e.data));
              check("out_tuser", 32'(axis_o_tuser), 32'(e.user));
              check("out_tlast", 32'(axis_o_tlast), 32'(e.last));
              rd_ptr[m_grant]++;
              if (e.last) begin
                m_busy = 1'b0;
                m_last = m_grant;
              end
            end
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [NS-1:0] hs;
    beat_t         b;
    bit            gen_en;
    bit            drained;
    int            len;
    int            bi;

    sreset        = 1'b1;
    axis_i_tvalid = '0;
    axis_i_tlast  = '0;
    axis_i_tdata  = '0;
    axis_i_tuser  = '0;
    axis_o_tready = 1'b0;
    for (int i = 0; i < NS; i++) begin
      wr_ptr[i] = 0; rd_ptr[i] = 0; drv_ptr[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 sreset = 1'b0;

    @(negedge clk);
    check("rst_tvalid", 32'(axis_o_tvalid), 32'd0);
    check("rst_tready", 32'(axis_i_tready), 32'd0);
    check("rst_tid", 32'(axis_o_tid), 32'd0);

    @(posedge clk);
    #1;
    m_busy  = 1'b0;
    m_grant = 0;
    m_last  = NS - 1;
    chk_en  = 1'b1;
    hs      = '0;
    drained = 1'b0;

    // Random traffic, then a bounded drain with generation disabled.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      gen_en = (cyc < 1500);
      for (int i = 0; i < NS; i++) begin
        if (hs[i]) drv_ptr[i]++;
        if (drv_ptr[i] == wr_ptr[i] && gen_en && $urandom_range(0, 2) == 0) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) begin
            exp_mem[i][wr_ptr[i] % DEPTH] = '{data: 8'($urandom), user: UB'($urandom),
                                             last: (k == len - 1)};
            wr_ptr[i]++;
          end
        end
        if (drv_ptr[i] < wr_ptr[i]) begin
          b = exp_mem[i][drv_ptr[i] % DEPTH];
          axis_i_tdata[i*8 +: 8]   = b.data;
          axis_i_tuser[i*UB +: UB] = b.user;
          axis_i_tlast[i]          = b.last;
          axis_i_tvalid[i]         = ($urandom_range(0, 4) != 0);
        end else begin
          axis_i_tvalid[i] = 1'b0;
          axis_i_tlast[i]  = 1'b0;
        end
      end
      axis_o_tready = ($urandom_range(0, 3) != 0);
      if (!gen_en && !m_busy) begin
        drained = 1'b1;
        for (int i = 0; i < NS; i++)
          if (drv_ptr[i] != wr_ptr[i] || rd_ptr[i] != wr_ptr[i]) drained = 1'b0;
        if (drained) break;
      end
      @(negedge clk);
      hs = axis_i_tvalid & axis_i_tready;
      @(posedge clk);
      #1;
    end
    check("drained", 32'(drained), 32'd1);

    // Directed: reset lands on beat 2 of a 5-beat packet from input 1.
    chk_en        = 1'b0;
    axis_i_tvalid = '0;
    sreset        = 1'b1;
    @(posedge clk);
    #1 sreset = 1'b0;
    axis_o_tready = 1'b1;
    bi = 0;
    axis_i_tvalid[1]   = 1'b1;
    axis_i_tdata[15:8] = 8'hA0;
    axis_i_tlast[1]    = 1'b0;
    for (int t = 0; t < 20 && bi < 2; t++) begin
      @(negedge clk);
      hs = axis_i_tvalid & axis_i_tready;
      @(posedge clk);
      #1;
      if (hs[1]) bi++;
      axis_i_tdata[15:8] = 8'hA0 + 8'(bi);
      axis_i_tlast[1]    = (bi == 4);
    end
    check("rstmid_setup", 32'(bi), 32'd2);
    @(negedge clk);
    check("rstmid_tid_before", 32'(axis_o_tid), 32'd1);
    check("rstmid_data_before", 32'(axis_o_tdata), 32'hA2);
    @(posedge clk);
    #1;
    sreset             = 1'b1;
    axis_i_tvalid[0]   = 1'b1;
    axis_i_tdata[7:0]  = 8'h55;
    axis_i_tlast[0]    = 1'b1;
    @(posedge clk);
    #1 sreset = 1'b0;
    @(negedge clk);
    check("rstmid_tvalid", 32'(axis_o_tvalid), 32'd0);
    check("rstmid_tready", 32'(axis_i_tready), 32'd0);
    check("rstmid_tid", 32'(axis_o_tid), 32'd0);
    @(negedge clk);
    $display("beat src=%0d data=%02h last=%0b", axis_o_tid, axis_o_tdata, axis_o_tlast);
    check("rstmid_grant_tid", 32'(axis_o_tid), 32'd0);
    check("rstmid_grant_tvalid", 32'(axis_o_tvalid), 32'd1);
    check("rstmid_grant_data", 32'(axis_o_tdata), 32'h55);
    check("rstmid_grant_tready", 32'(axis_i_tready), 32'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
